// File: rtl/ordering_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// ordering_xfer_ctrl_if
// Bundles every non-clock signal of ordering_xfer_ctrl: the command
// handshake, the host write and read streams, the node_reg beat interface
// and the status outputs.
//   slave  : view used by the controller
//   master : view used by the host / node_reg side (or a testbench)
// Signal names follow the block's port list; widths come from CITY_DIV_LOG.
// ---------------------------------------------------------------------------
interface ordering_xfer_ctrl_if #(
  parameter int CITY_DIV_LOG = 4
);
  // command
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [CITY_DIV_LOG-1:0] cmd_beats_m1;
  // host write stream
  logic                    wr_valid;
  logic                    wr_ready;
  logic [63:0]             wr_data;
  // host read stream
  logic                    rd_valid;
  logic                    rd_ready;
  logic [63:0]             rd_data;
  // node_reg side
  logic [CITY_DIV_LOG-1:0] ordering_num;
  logic                    ordering_write;
  logic [63:0]             ordering_wdata;
  logic                    ordering_read;
  logic [63:0]             ordering_rdata;
  logic                    ordering_ready;
  // status
  logic                    busy;
  logic                    done;
  logic [31:0]             stall_cycles;

  modport slave (
    input  cmd_valid, cmd_write, cmd_beats_m1,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    input  rd_ready,
    output rd_valid, rd_data,
    input  ordering_rdata, ordering_ready,
    output ordering_num, ordering_write, ordering_wdata, ordering_read,
    output busy, done, stall_cycles
  );

  modport master (
    output cmd_valid, cmd_write, cmd_beats_m1,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    output rd_ready,
    input  rd_valid, rd_data,
    output ordering_rdata, ordering_ready,
    input  ordering_num, ordering_write, ordering_wdata, ordering_read,
    input  busy, done, stall_cycles
  );
endinterface

// File: rtl/ordering_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// ordering_xfer_ctrl
// Sequences host transfers of the ordering (city tour) buffer through
// node_reg. One command (write or read) produces (ordering_num+1) beats per
// node for NODE_NUM nodes. Writes pass host beats straight to node_reg; reads
// issue strobes into node_reg and collect its 2-cycle-late data in a small
// return FIFO so host backpressure never loses a beat.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : ordering_xfer_ctrl_if.slave (command, write/read streams,
//                node_reg beat interface, busy/done/stall_cycles)
//
// Optional build macro:
//   ORDERING_XFER_PERF_EN : when defined, stall_cycles counts cycles where a
//                           beat was wanted but could not be taken (saturating,
//                           cleared on command acceptance). Otherwise it is 0.
// ---------------------------------------------------------------------------
module ordering_xfer_ctrl #(
  parameter int NODE_NUM     = 32,
  parameter int CITY_DIV_LOG = 4,
  parameter int RFIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic reset,
  ordering_xfer_ctrl_if.slave bus
);

  localparam int NW = $clog2(NODE_NUM);
  localparam int AW = $clog2(RFIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [CITY_DIV_LOG-1:0] r_num;
  logic [CITY_DIV_LOG-1:0] r_beat;
  logic [NW-1:0]           r_node;

  // read-return FIFO
  logic [63:0] r_mem [RFIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  // one token per accepted read beat, aligned with node_reg's read latency
  logic [1:0]    r_dly;

  logic        w_cmd_acc;
  logic        w_wr_stb;
  logic        w_rd_stb;
  logic        w_rd_acc;
  logic        w_acc;
  logic        w_last;
  logic        w_room;
  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_inflight;

  // ---------------------------------------------------------------------
  // strobes and beat acceptance
  // ---------------------------------------------------------------------
  assign w_inflight = {{AW{1'b0}}, r_dly[0]} + {{AW{1'b0}}, r_dly[1]};
  // count beats already owed to the FIFO so data landing 2 cycles later
  // always has a free slot
  assign w_room     = (r_cnt + w_inflight) < (AW+1)'(RFIFO_DEPTH);

  assign w_cmd_acc  = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_wr_stb   = (r_state == S_WRITE) && bus.wr_valid;
  assign w_rd_stb   = (r_state == S_READ) && w_room;
  assign w_rd_acc   = w_rd_stb && bus.ordering_ready;
  assign w_acc      = (w_wr_stb || w_rd_stb) && bus.ordering_ready;
  assign w_last     = (r_beat == r_num) && (r_node == NW'(NODE_NUM - 1));

  assign w_push     = r_dly[1];
  assign w_pop      = (r_cnt != '0) && bus.rd_ready;

  assign bus.cmd_ready      = (r_state == S_IDLE);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = (r_state == S_DONE);
  assign bus.wr_ready       = (r_state == S_WRITE) && bus.ordering_ready;
  assign bus.ordering_write = w_wr_stb;
  assign bus.ordering_wdata = bus.wr_data;
  assign bus.ordering_read  = w_rd_stb;
  assign bus.ordering_num   = r_num;
  assign bus.rd_valid       = (r_cnt != '0);
  assign bus.rd_data        = r_mem[r_rptr];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.cmd_valid) w_next = bus.cmd_write ? S_WRITE : S_READ;
      S_WRITE: if (w_acc && w_last) w_next = S_DONE;
      S_READ:  if (w_acc && w_last) w_next = S_DRAIN;
      // FIFO empty means no pop can be pending either
      S_DRAIN: if ((r_dly == 2'b00) && (r_cnt == '0)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // beat / node counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num  <= '0;
      r_beat <= '0;
      r_node <= '0;
    end else if (w_cmd_acc) begin
      r_num  <= bus.cmd_beats_m1;
      r_beat <= '0;
      r_node <= '0;
    end else if (w_acc) begin
      if (r_beat == r_num) begin
        r_beat <= '0;
        r_node <= r_node + 1'b1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // read latency delay line and return FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dly  <= 2'b00;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_dly <= {r_dly[0], w_rd_acc};
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.ordering_rdata;
  end

  // ---------------------------------------------------------------------
  // stall counter
  // ---------------------------------------------------------------------
`ifdef ORDERING_XFER_PERF_EN
  logic [31:0] r_stall;
  logic        w_stall;

  // read cycles lose a beat either to FIFO gating or to node_reg not ready
  assign w_stall = ((r_state == S_WRITE) && bus.wr_valid && !bus.ordering_ready) ||
                   ((r_state == S_READ) && (!w_room || !bus.ordering_ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_stall <= '0;
    else if (w_cmd_acc)                 r_stall <= '0;
    else if (w_stall && (r_stall != '1)) r_stall <= r_stall + 1'b1;
  end

  assign bus.stall_cycles = r_stall;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ordering_xfer_ctrl.sv
module tb_ordering_xfer_ctrl;
  localparam int NODE_NUM = 32;
  localparam int CDL      = 4;
  localparam int DEPTH    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ordering_xfer_ctrl_if #(.CITY_DIV_LOG(CDL)) bus();

  ordering_xfer_ctrl #(
    .NODE_NUM    (NODE_NUM),
    .CITY_DIV_LOG(CDL),
    .RFIFO_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // scoreboard queues
  logic [63:0] wq[$];
  logic [63:0] rq[$];

  // monitor statistics
  int cyc = 0;
  int n_cmd = 0, n_done = 0, n_wbeat = 0, n_rd_iss = 0, n_pop = 0, max_out = 0;
  int first_w = -1, last_w = -1, last_pop = -1;
  int done_stall = 0, done_rq_left = 0;
  int cmd_q[$];
  int done_q[$];

  // stimulus-side state
  int  wr_idx = 0;
  int  ridx   = 0;
  bit  tgl_en = 1'b0;

  function automatic logic [63:0] wpat(input int i);
    return {32'hC0DE_0000 + 32'(i), ~32'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // monitor: samples on the falling edge, when all inputs are settled
  // ---------------------------------------------------------------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          n_cmd++;
          cmd_q.push_back(cyc);
        end
        if (bus.ordering_write && bus.ordering_ready) begin
          if (first_w < 0) first_w = cyc;
          last_w = cyc;
          n_wbeat++;
          if (wq.size() == 0) chk("wbeat_unexpected", bus.ordering_wdata, 64'hx);
          else begin
            e = wq.pop_front();
            chk("wdata", bus.ordering_wdata, e);
          end
        end
        if (bus.ordering_read && bus.ordering_ready) n_rd_iss++;
        if (bus.rd_valid && bus.rd_ready) begin
          n_pop++;
          last_pop = cyc;
          if (rq.size() == 0) chk("rbeat_unexpected", bus.rd_data, 64'hx);
          else begin
            e = rq.pop_front();
            chk("rdata", bus.rd_data, e);
          end
        end
        if (n_rd_iss - n_pop > max_out) max_out = n_rd_iss - n_pop;
        if (bus.done) begin
          n_done++;
          done_q.push_back(cyc);
          done_stall   = int'(bus.stall_cycles);
          done_rq_left = rq.size();
        end
      end
    end
  end

  // host write source: next beat once the current one is taken
  initial begin
    bit t;
    bus.wr_data = wpat(0);
    forever begin
      @(negedge clk);
      t = bus.wr_valid && bus.wr_ready;
      @(posedge clk);
      #1;
      if (reset) wr_idx = 0;
      else if (t) wr_idx++;
      bus.wr_data = wpat(wr_idx);
    end
  end

  // node_reg model: read data returned 2 cycles after acceptance
  initial begin
    bit a;
    logic [63:0] p0, p1;
    p0 = '0; p1 = '0;
    bus.ordering_rdata = '0;
    forever begin
      @(negedge clk);
      a = bus.ordering_read && bus.ordering_ready;
      @(posedge clk);
      #1;
      if (reset) begin
        p0 = '0; p1 = '0; ridx = 0;
      end else begin
        p1 = p0;
        p0 = a ? 64'(ridx) : 64'hDEAD_DEAD_DEAD_DEAD;
        if (a) ridx++;
      end
      bus.ordering_rdata = p1;
    end
  end

  // node_reg ready: constant 1, or alternating once write beats start
  initial begin
    bit s;
    bus.ordering_ready = 1'b1;
    forever begin
      @(negedge clk);
      s = bus.ordering_write;
      @(posedge clk);
      #1;
      if (!tgl_en) bus.ordering_ready = 1'b1;
      else if (s)  bus.ordering_ready = ~bus.ordering_ready;
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  task automatic issue(input bit wr, input int m1);
    int n;
    n = (m1 + 1) * NODE_NUM;
    @(posedge clk); #1;
    if (wr) for (int k = 0; k < n; k++) wq.push_back(wpat(wr_idx + k));
    else    for (int k = 0; k < n; k++) rq.push_back(64'(ridx + k));
    bus.cmd_valid    = 1'b1;
    bus.cmd_write    = wr;
    bus.cmd_beats_m1 = CDL'(m1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int d0;
    bit ok;
    d0 = n_done;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (n_done > d0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s: done not seen within %0d cycles", name, bound);
    end
    #1;
  endtask

  task automatic clr_stats();
    n_wbeat = 0; n_rd_iss = 0; n_pop = 0; max_out = 0;
    first_w = -1; last_w = -1; last_pop = -1;
    cmd_q.delete(); done_q.delete();
  endtask

  initial begin
    int d0, c0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_write    = 1'b0;
    bus.cmd_beats_m1 = '0;
    bus.wr_valid     = 1'b0;
    bus.rd_ready     = 1'b1;

    // --- reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy",      64'(bus.busy), 64'd0);
    chk("rst_done",      64'(bus.done), 64'd0);
    chk("rst_wr_ready",  64'(bus.wr_ready), 64'd0);
    chk("rst_owrite",    64'(bus.ordering_write), 64'd0);
    chk("rst_oread",     64'(bus.ordering_read), 64'd0);
    chk("rst_rd_valid",  64'(bus.rd_valid), 64'd0);
    chk("rst_onum",      64'(bus.ordering_num), 64'd0);
    chk("rst_stall",     64'(bus.stall_cycles), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // --- write, 4 beats x 32 nodes, no backpressure
    clr_stats();
    bus.wr_valid = 1'b1;
    d0 = n_done;
    issue(1'b1, 3);
    wait_done(400, "w128_done");
    @(negedge clk);
    chk("w128_cmd_ready_after_done", 64'(bus.cmd_ready), 64'd1);
    chk("w128_beats", 64'(n_wbeat), 64'd128);
    chk("w128_span",  64'(last_w - first_w + 1), 64'd128);
    chk("w128_done_cycle", 64'(done_q[0]), 64'(last_w + 1));
    chk("w128_onum",  64'(bus.ordering_num), 64'd3);
    chk("w128_wq_empty", 64'(wq.size()), 64'd0);
    repeat (5) @(negedge clk);
    chk("w128_one_done", 64'(n_done - d0), 64'd1);
    bus.wr_valid = 1'b0;

    // --- read, 2 beats x 32 nodes, host always ready
    clr_stats();
    issue(1'b0, 1);
    wait_done(600, "r64_done");
    chk("r64_pops", 64'(n_pop), 64'd64);
    chk("r64_rq_empty_at_done", 64'(done_rq_left), 64'd0);
    chk("r64_done_after_pop", 64'(last_pop < done_q[0]), 64'd1);

    // --- read with host stalled for 20 cycles
    clr_stats();
    bus.rd_ready = 1'b0;
    issue(1'b0, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rbp_oread_gated", 64'(bus.ordering_read), 64'd0);
    chk("rbp_issued", 64'(n_rd_iss), 64'd4);
    chk("rbp_rd_valid", 64'(bus.rd_valid), 64'd1);
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    wait_done(800, "rbp_done");
    chk("rbp_pops", 64'(n_pop), 64'd64);
    chk("rbp_max_out", 64'(max_out), 64'(DEPTH));
    chk("rbp_rq_empty", 64'(rq.size()), 64'd0);

    // --- write with ordering_ready alternating
    clr_stats();
    bus.wr_valid = 1'b1;
    tgl_en = 1'b1;
    issue(1'b1, 3);
    wait_done(800, "wtg_done");
    tgl_en = 1'b0;
    chk("wtg_beats", 64'(n_wbeat), 64'd128);
    chk("wtg_span",  64'(last_w - first_w + 1), 64'd255);
`ifdef ORDERING_XFER_PERF_EN
    chk("wtg_stall", 64'(done_stall), 64'd127);
    repeat (3) @(negedge clk);
    chk("wtg_stall_hold", 64'(bus.stall_cycles), 64'd127);
`else
    chk("wtg_stall", 64'(done_stall), 64'd0);
`endif
    bus.wr_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // --- reset in the middle of a read
    clr_stats();
    issue(1'b0, 3);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (n_rd_iss >= 10) break;
    end
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy",      64'(bus.busy), 64'd0);
    chk("mrst_rd_valid",  64'(bus.rd_valid), 64'd0);
    chk("mrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mrst_oread",     64'(bus.ordering_read), 64'd0);
    rq.delete();
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    clr_stats();
    bus.wr_valid = 1'b1;
    issue(1'b1, 0);
    wait_done(200, "mrst_w_done");
    chk("mrst_w_beats", 64'(n_wbeat), 64'd32);
    chk("mrst_wq_empty", 64'(wq.size()), 64'd0);
    chk("mrst_rd_valid_after", 64'(bus.rd_valid), 64'd0);

    // --- cmd_valid held high across a write
    clr_stats();
    d0 = n_done;
    c0 = n_cmd;
    @(posedge clk); #1;
    for (int k = 0; k < 2 * NODE_NUM; k++) wq.push_back(wpat(wr_idx + k));
    bus.cmd_valid    = 1'b1;
    bus.cmd_write    = 1'b1;
    bus.cmd_beats_m1 = '0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_cmd - c0 >= 2) break;
    end
    #1;
    bus.cmd_valid = 1'b0;
    wait_done(200, "hold_done2");
    repeat (5) @(negedge clk);
    chk("hold_cmds", 64'(n_cmd - c0), 64'd2);
    chk("hold_dones", 64'(n_done - d0), 64'd2);
    if (cmd_q.size() >= 2 && done_q.size() >= 1) begin
      chk("hold_cmd_gap", 64'(cmd_q[1] - cmd_q[0]), 64'd34);
      chk("hold_after_done", 64'(cmd_q[1]), 64'(done_q[0] + 1));
    end else begin
      chk("hold_events", 64'(cmd_q.size()), 64'd2);
    end
    chk("hold_beats", 64'(n_wbeat), 64'd64);
    chk("hold_wq_empty", 64'(wq.size()), 64'd0);
    bus.wr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
